// File: rtl/decoder3to8_seq.sv
`default_nettype none
// decoder3to8_seq: buffered 3-to-8 decoder that holds each one-hot word for
// HOLD_CYCLES cycles and then drives GAP_CYCLES all-zero cycles. Rev 1.0
module decoder3to8_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic       en,
  output logic [7:0] onehot_out,
  output logic       busy,
  output logic [7:0] decode_count
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP   = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic [7:0] onehot_n;
  logic [7:0] count_n;
  logic [2:0] pend_code;
  logic       pend_valid;
  logic       consume;
  logic       accept;

  assign code_ready = !pend_valid;
  assign busy       = (state != IDLE);
  // consume needs pend_valid=1 and accept needs pend_valid=0, so they never coincide
  assign accept     = code_valid && !pend_valid;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    onehot_n = onehot_out;
    count_n  = decode_count;
    consume  = 1'b0;
    case (state)
      IDLE: begin
        onehot_n = 8'h00;
        if (pend_valid && en) consume = 1'b1;
      end
      DRIVE: begin
        if (timer != 8'd0) begin
          timer_n = timer - 8'd1;
        end else if (HAS_GAP) begin
          state_n  = GAP;
          onehot_n = 8'h00;
          timer_n  = GAP_LOAD;
        end else if (pend_valid && en) begin
          consume = 1'b1;
        end else begin
          state_n  = IDLE;
          onehot_n = 8'h00;
        end
      end
      GAP: begin
        onehot_n = 8'h00;
        if (timer != 8'd0) timer_n = timer - 8'd1;
        else               state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        onehot_n = 8'h00;
        timer_n  = 8'd0;
      end
    endcase
    // Starting a word is identical from IDLE and from a gapless DRIVE reload
    if (consume) begin
      state_n  = DRIVE;
      onehot_n = 8'b1 << pend_code;
      timer_n  = HOLD_LOAD;
      count_n  = decode_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= 8'd0;
      onehot_out   <= 8'h00;
      decode_count <= 8'd0;
      pend_valid   <= 1'b0;
      pend_code    <= 3'd0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      onehot_out   <= onehot_n;
      decode_count <= count_n;
      if (consume) begin
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_valid <= 1'b1;
        pend_code  <= code_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder3to8_seq.sv
`default_nettype none
// tb_decoder3to8_seq: two instances (HOLD=4/GAP=1 and HOLD=2/GAP=0) checked
// every cycle against a schedule-queue model, plus directed literal checks.
module tb_decoder3to8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code_in;
  logic       code_valid;
  logic       en;
  logic       ready [2];
  logic [7:0] oh    [2];
  logic       busy  [2];
  logic [7:0] cnt   [2];

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready[0]), .en(en), .onehot_out(oh[0]), .busy(busy[0]),
    .decode_count(cnt[0])
  );

  decoder3to8_seq #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready[1]), .en(en), .onehot_out(oh[1]), .busy(busy[1]),
    .decode_count(cnt[1])
  );

  // Model: each instance owns a queue of future {busy, onehot} cycles. Starting
  // a word schedules HOLD words, GAP busy zeros and (if GAP>0) one idle cycle.
  int         hold_c [2] = '{4, 2};
  int         gap_c  [2] = '{1, 0};
  logic [8:0] ring   [2][16];
  int         head   [2];
  int         len    [2];
  logic [7:0] m_out  [2];
  logic       m_busy [2];
  logic [7:0] m_cnt  [2];
  logic       m_pend [2];
  logic [2:0] m_code [2];

  task automatic push(input int i, input logic [8:0] v);
    ring[i][(head[i] + len[i]) % 16] = v;
    len[i]++;
  endtask

  task automatic model_step(input int i);
    logic [8:0] e;
    logic       old_pend;
    if (!rst_n) begin
      len[i] = 0; head[i] = 0; m_pend[i] = 1'b0; m_cnt[i] = 8'd0;
      m_out[i] = 8'h00; m_busy[i] = 1'b0;
    end else begin
      old_pend = m_pend[i];
      if (len[i] > 0) begin
        e = ring[i][head[i]];
        head[i] = (head[i] + 1) % 16;
        len[i]--;
        m_busy[i] = e[8];
        m_out[i]  = e[7:0];
      end else if (old_pend && en) begin
        m_out[i]  = 8'(1 << m_code[i]);
        m_busy[i] = 1'b1;
        m_cnt[i]  = m_cnt[i] + 8'd1;
        m_pend[i] = 1'b0;
        repeat (hold_c[i] - 1) push(i, {1'b1, m_out[i]});
        repeat (gap_c[i]) push(i, 9'h100);
        if (gap_c[i] > 0) push(i, 9'h000);
      end else begin
        m_out[i]  = 8'h00;
        m_busy[i] = 1'b0;
      end
      if (code_valid && !old_pend) begin
        m_pend[i] = 1'b1;
        m_code[i] = code_in;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("onehot", i, 32'(oh[i]), 32'(m_out[i]));
        chk("busy", i, 32'(busy[i]), 32'(m_busy[i]));
        chk("count", i, 32'(cnt[i]), 32'(m_cnt[i]));
        chk("ready", i, 32'(ready[i]), 32'(!m_pend[i]));
        chk("onehot0", i, 32'($onehot0(oh[i])), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    code_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    int guard;
    logic acc;

    rst_n = 1'b0; en = 1'b1; code_valid = 1'b1; code_in = 3'd5;
    tick();
    cmp_on = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_onehot", i, 32'(oh[i]), 32'h0);
      chk("rst_busy", i, 32'(busy[i]), 32'h0);
      chk("rst_count", i, 32'(cnt[i]), 32'h0);
      chk("rst_ready", i, 32'(ready[i]), 32'h1);
    end
    code_valid = 1'b0; rst_n = 1'b1;
    tick();
    chk("rst_nocapture", 0, 32'(ready[0]), 32'h1);

    // Single code 5 on the HOLD=4/GAP=1 instance
    code_in = 3'd5; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("single_ready", 0, 32'(ready[0]), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("single_hold", 0, 32'(oh[0]), 32'h20);
    end
    tick();
    chk("single_gap", 0, 32'(oh[0]), 32'h00);
    chk("single_gapbusy", 0, 32'(busy[0]), 32'h1);
    tick();
    chk("single_idle", 0, 32'(busy[0]), 32'h0);
    chk("single_count", 0, 32'(cnt[0]), 32'h1);

    // Back-to-back words on the gapless instance
    reset_dut();
    code_in = 3'd3; code_valid = 1'b1;
    tick();
    code_in = 3'd6;
    tick();
    chk("b2b_w0", 1, 32'(oh[1]), 32'h08);
    tick();
    code_valid = 1'b0;
    chk("b2b_w1", 1, 32'(oh[1]), 32'h08);
    tick();
    chk("b2b_w2", 1, 32'(oh[1]), 32'h40);
    tick();
    chk("b2b_w3", 1, 32'(oh[1]), 32'h40);
    tick();
    chk("b2b_end", 1, 32'(oh[1]), 32'h00);

    // en gating
    reset_dut();
    en = 1'b0; code_in = 3'd2; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("en_off_onehot", 0, 32'(oh[0]), 32'h00);
      chk("en_off_ready", 0, 32'(ready[0]), 32'h0);
    end
    en = 1'b1;
    tick();
    chk("en_on_onehot", 0, 32'(oh[0]), 32'h04);

    // Reset during a hold with a code pending
    reset_dut();
    code_in = 3'd7; code_valid = 1'b1;
    tick();
    code_in = 3'd1;
    tick();
    tick();
    code_valid = 1'b0;
    chk("mid_hold", 0, 32'(oh[0]), 32'h80);
    chk("mid_pending", 0, 32'(ready[0]), 32'h0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_onehot", 0, 32'(oh[0]), 32'h00);
    chk("mid_rst_ready", 0, 32'(ready[0]), 32'h1);
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      chk("mid_no02", 0, 32'(oh[0] == 8'h02), 32'h0);
    end

    // Stream codes 0..7 with valid held
    reset_dut();
    idx = 0; guard = 0; code_in = 3'd0; code_valid = 1'b1;
    while (idx < 8 && guard < 500) begin
      acc = ready[0];
      tick();
      guard++;
      if (acc) begin
        idx++;
        code_in = 3'(idx);
      end
    end
    code_valid = 1'b0;
    chk("stream_accepts", 0, 32'(idx), 32'd8);
    repeat (60) tick();
    chk("stream_count", 0, 32'(cnt[0]), 32'd8);

    // Randomized traffic
    repeat (3000) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      en         = ($urandom_range(0, 4) != 0);
      code_valid = 1'($urandom_range(0, 1));
      code_in    = 3'($urandom);
      tick();
    end

    // 256 decodes wrap the counter on the gapless instance
    reset_dut();
    en = 1'b1; idx = 0; guard = 0; code_in = 3'($urandom); code_valid = 1'b1;
    while (idx < 256 && guard < 3000) begin
      acc = ready[1];
      tick();
      guard++;
      if (acc) begin
        idx++;
        code_in = 3'($urandom);
        code_valid = (idx < 256);
      end
    end
    code_valid = 1'b0;
    chk("wrap_accepts", 1, 32'(idx), 32'd256);
    repeat (20) tick();
    chk("wrap_count", 1, 32'(cnt[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
